// File: rtl/eth_tx_pktgen.sv
// Application-side traffic generator for eth_tx: bursts of LFSR-payload packets
// with fixed or incrementing length, inter-packet gap and cancellation.
module eth_tx_pktgen #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BLOCK_N   = 8,
    parameter int unsigned PKT_LEN_W = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned GAP_W     = 8,
    parameter logic [31:0] LFSR_SEED = 32'h1
) (
    input  logic                                   clk,
    input  logic                                   nreset,
    input  logic                                   start_i,
    input  logic                                   abort_i,
    input  logic [CNT_W-1:0]                       pkt_cnt_i,
    input  logic [PKT_LEN_W-1:0]                   len_min_i,
    input  logic [PKT_LEN_W-1:0]                   len_max_i,
    input  logic                                   len_inc_i,
    input  logic [GAP_W-1:0]                       gap_i,
    input  logic                                   app_ready_v_i,
    output logic                                   app_early_v_o,
    output logic                                   app_cancel_o,
    output logic [DATA_W-1:0]                      app_data_o,
    output logic [$clog2(DATA_W/8+1)-1:0]          app_len_o,
    output logic [PKT_LEN_W-1:0]                   app_pkt_len_o,
    output logic [15:0]                            app_cs_o,
    output logic                                   app_last_o,
    output logic                                   app_last_block_next_o,
    output logic [$clog2(BLOCK_N+DATA_W/8+1)-1:0]  app_last_block_next_len_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [CNT_W-1:0]                       pkt_sent_o
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned KB     = $clog2(KEEP_W);
    localparam int unsigned LEN_W  = $clog2(KEEP_W + 1);
    localparam int unsigned LBL_W  = $clog2(BLOCK_N + KEEP_W + 1);
    localparam int unsigned OFF_W  = PKT_LEN_W + KB;
    localparam logic [OFF_W-1:0] BLK = OFF_W'(BLOCK_N);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        DATA = 3'd2,
        LAST = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     sent_q;
    logic [PKT_LEN_W-1:0] len_min_q;
    logic [PKT_LEN_W-1:0] len_max_q;
    logic                 inc_q;
    logic [GAP_W-1:0]     gap_q;
    logic [GAP_W-1:0]     gap_cnt_q;
    logic [PKT_LEN_W-1:0] len_q;
    logic [PKT_LEN_W-1:0] beat_q;
    logic [31:0]          lfsr_q;
    logic                 done_q;

    logic [PKT_LEN_W-1:0] full_beats;
    logic [KB-1:0]        rem;
    logic                 last_data_beat;
    logic [CNT_W-1:0]     sent_inc;
    logic                 burst_end;
    logic [31:0]          lfsr_nxt;
    logic [DATA_W-1:0]    word;
    logic [OFF_W-1:0]     off;
    logic [OFF_W-1:0]     len_ext;
    logic                 lbn;

    assign full_beats     = len_q >> KB;
    assign rem            = len_q[KB-1:0];
    assign last_data_beat = (beat_q + PKT_LEN_W'(1)) == full_beats;
    assign sent_inc       = sent_q + CNT_W'(1);
    assign burst_end      = (cnt_q != '0) && (sent_inc == cnt_q);
    assign lfsr_nxt       = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

    // Payload is the low DATA_W bits of {lfsr, ~lfsr}
    if (DATA_W > 32) begin : g_wide
        assign word = {lfsr_q[DATA_W-33:0], ~lfsr_q};
    end else begin : g_narrow
        assign word = ~lfsr_q[DATA_W-1:0];
    end

    // Beat starts at a block boundary that is the packet's final (partial) block
    assign off     = {beat_q, {KB{1'b0}}};
    assign len_ext = OFF_W'(len_q);
    assign lbn     = ((off % BLK) == '0) && ((off / BLK) == (len_ext / BLK));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = REQ;
            REQ: begin
                if (abort_i)            state_d = GAP;
                else if (app_ready_v_i) state_d = (full_beats != '0) ? DATA : LAST;
            end
            DATA: begin
                if (abort_i)             state_d = GAP;
                else if (last_data_beat) state_d = LAST;
            end
            LAST: begin
                if (abort_i)          state_d = GAP;
                else if (burst_end)   state_d = IDLE;
                else if (gap_q == '0) state_d = REQ;
                else                  state_d = GAP;
            end
            GAP:     if (gap_cnt_q <= GAP_W'(1)) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // Burst configuration, packet length, beat index, payload LFSR and counters
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q     <= '0;
            sent_q    <= '0;
            len_min_q <= '0;
            len_max_q <= '0;
            inc_q     <= 1'b0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_q     <= pkt_cnt_i;
                        len_min_q <= len_min_i;
                        len_max_q <= len_max_i;
                        inc_q     <= len_inc_i;
                        gap_q     <= gap_i;
                        len_q     <= len_min_i;
                        sent_q    <= '0;
                        lfsr_q    <= LFSR_SEED;
                    end
                end
                REQ: beat_q <= '0;
                DATA: begin
                    lfsr_q <= lfsr_nxt;
                    beat_q <= beat_q + PKT_LEN_W'(1);
                end
                LAST: begin
                    lfsr_q <= lfsr_nxt;
                    if (!abort_i) begin
                        sent_q <= sent_inc;
                        done_q <= burst_end;
                        if (inc_q && (len_max_q >= len_min_q))
                            len_q <= (len_q == len_max_q) ? len_min_q : len_q + PKT_LEN_W'(1);
                    end
                end
                GAP:     gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                default: ;
            endcase
            if ((state_d == GAP) && (state_q != GAP))
                gap_cnt_q <= gap_q;
        end
    end

    // Output decode; abort suppresses request/last in the same cycle
    always_comb begin
        app_early_v_o             = 1'b0;
        app_cancel_o              = 1'b0;
        app_data_o                = '0;
        app_len_o                 = '0;
        app_pkt_len_o             = '0;
        app_cs_o                  = 16'h0;
        app_last_o                = 1'b0;
        app_last_block_next_o     = 1'b0;
        app_last_block_next_len_o = '0;
        busy_o                    = (state_q != IDLE);
        done_o                    = done_q;
        pkt_sent_o                = sent_q;
        case (state_q)
            REQ: begin
                app_early_v_o = !abort_i;
                app_cancel_o  = abort_i;
                app_pkt_len_o = len_q;
            end
            DATA: begin
                app_cancel_o  = abort_i;
                app_pkt_len_o = len_q;
                app_data_o    = word;
                app_len_o     = LEN_W'(KEEP_W);
                if (lbn) begin
                    app_last_block_next_o     = 1'b1;
                    app_last_block_next_len_o = LBL_W'(len_q % PKT_LEN_W'(BLOCK_N));
                end
            end
            LAST: begin
                app_cancel_o  = abort_i;
                app_last_o    = !abort_i;
                app_pkt_len_o = len_q;
                app_len_o     = LEN_W'(rem);
                app_data_o    = word;
                for (int b = 0; b < KEEP_W; b++)
                    if (KB'(b) >= rem) app_data_o[b*8 +: 8] = 8'h00;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_pktgen.sv
// Directed bench for eth_tx_pktgen (DATA_W=16, BLOCK_N=8): fixed/incrementing
// lengths, ready stall, abort, and asynchronous reset mid-packet.
module tb_eth_tx_pktgen;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start_i, abort_i, len_inc_i, app_ready_v_i;
    logic [15:0] pkt_cnt_i, len_min_i, len_max_i;
    logic [7:0]  gap_i;
    logic        app_early_v_o, app_cancel_o, app_last_o, app_last_block_next_o;
    logic [15:0] app_data_o, app_pkt_len_o, app_cs_o, pkt_sent_o;
    logic [1:0]  app_len_o;
    logic [3:0]  app_last_block_next_len_o;
    logic        busy_o, done_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_lfsr;

    eth_tx_pktgen dut (
        .clk(clk), .nreset(nreset), .start_i(start_i), .abort_i(abort_i),
        .pkt_cnt_i(pkt_cnt_i), .len_min_i(len_min_i), .len_max_i(len_max_i),
        .len_inc_i(len_inc_i), .gap_i(gap_i), .app_ready_v_i(app_ready_v_i),
        .app_early_v_o(app_early_v_o), .app_cancel_o(app_cancel_o),
        .app_data_o(app_data_o), .app_len_o(app_len_o), .app_pkt_len_o(app_pkt_len_o),
        .app_cs_o(app_cs_o), .app_last_o(app_last_o),
        .app_last_block_next_o(app_last_block_next_o),
        .app_last_block_next_len_o(app_last_block_next_len_o),
        .busy_o(busy_o), .done_o(done_o), .pkt_sent_o(pkt_sent_o)
    );

    always #5 clk = ~clk;

    // Polynomial x^32+x^22+x^2+x+1, shifting left
    function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    task automatic do_start(input logic [15:0] cnt, input logic [15:0] mn,
                            input logic [15:0] mx, input logic inc, input logic [7:0] gap);
        @(negedge clk);
        pkt_cnt_i = cnt; len_min_i = mn; len_max_i = mx; len_inc_i = inc; gap_i = gap;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        m_lfsr = 32'h1;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 200 && busy_o; k++) @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL %s timeout: busy=%b expected 0", name, busy_o);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({app_early_v_o, app_cancel_o, app_last_o, busy_o, done_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000",
                              {app_early_v_o, app_cancel_o, app_last_o, busy_o, done_o});
        end
        n_cmp++;
        if ({app_data_o, app_pkt_len_o, pkt_sent_o, app_cs_o} !== 64'h0) begin
            n_err++; $display("FAIL reset_words: data=%h plen=%h sent=%h cs=%h expected 0",
                              app_data_o, app_pkt_len_o, pkt_sent_o, app_cs_o);
        end
        @(negedge clk);
        nreset = 1'b1;
        abort_i = 1'b1;
        #1;
        n_cmp++;
        if (app_cancel_o !== 1'b0) begin
            n_err++; $display("FAIL idle_abort: cancel=%b expected 0", app_cancel_o);
        end
        @(negedge clk);
        abort_i = 1'b0;
    endtask

    task automatic test_fixed20;
        do_start(16'd1, 16'd20, 16'd20, 1'b0, 8'd0);
        n_cmp++;
        if (app_early_v_o !== 1'b1 || app_pkt_len_o !== 16'd20) begin
            n_err++; $display("FAIL f20_req: early=%b plen=%0d expected 1/20", app_early_v_o, app_pkt_len_o);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (app_len_o !== 2'd2 || app_last_o !== 1'b0 || app_data_o !== ~m_lfsr[15:0]) begin
                n_err++; $display("FAIL f20_beat%0d: len=%0d last=%b data=%h expected 2/0/%h",
                                  i, app_len_o, app_last_o, app_data_o, ~m_lfsr[15:0]);
            end
            n_cmp++;
            if (app_last_block_next_o !== (i == 8) ||
                app_last_block_next_len_o !== ((i == 8) ? 4'd4 : 4'd0)) begin
                n_err++; $display("FAIL f20_lbn%0d: lbn=%b len=%0d", i,
                                  app_last_block_next_o, app_last_block_next_len_o);
            end
            m_lfsr = lfsr_adv(m_lfsr);
            @(negedge clk);
        end
        n_cmp++;
        if (app_last_o !== 1'b1 || app_len_o !== 2'd0 || app_data_o !== 16'h0 || pkt_sent_o !== 16'd0) begin
            n_err++; $display("FAIL f20_last: last=%b len=%0d data=%h sent=%0d expected 1/0/0000/0",
                              app_last_o, app_len_o, app_data_o, pkt_sent_o);
        end
        @(negedge clk);
        n_cmp++;
        if (done_o !== 1'b1 || pkt_sent_o !== 16'd1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL f20_done: done=%b sent=%0d busy=%b expected 1/1/0",
                              done_o, pkt_sent_o, busy_o);
        end
        @(negedge clk);
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_err++; $display("FAIL f20_done_pulse: done=%b expected 0", done_o);
        end
    endtask

    task automatic test_len5;
        do_start(16'd1, 16'd5, 16'd5, 1'b0, 8'd0);
        @(negedge clk);
        n_cmp++;
        if (app_data_o !== 16'hFFFE || app_last_block_next_o !== 1'b1 ||
            app_last_block_next_len_o !== 4'd5) begin
            n_err++; $display("FAIL l5_beat0: data=%h lbn=%b lbl=%0d expected fffe/1/5",
                              app_data_o, app_last_block_next_o, app_last_block_next_len_o);
        end
        @(negedge clk);
        n_cmp++;
        if (app_data_o !== 16'hFFFC || app_last_block_next_o !== 1'b0 || app_last_o !== 1'b0) begin
            n_err++; $display("FAIL l5_beat1: data=%h lbn=%b last=%b expected fffc/0/0",
                              app_data_o, app_last_block_next_o, app_last_o);
        end
        @(negedge clk);
        n_cmp++;
        if (app_last_o !== 1'b1 || app_len_o !== 2'd1 || app_data_o !== 16'h00F9) begin
            n_err++; $display("FAIL l5_last: last=%b len=%0d data=%h expected 1/1/00f9",
                              app_last_o, app_len_o, app_data_o);
        end
        wait_idle("l5");
    endtask

    task automatic test_inc;
        logic [15:0] exp_len [5] = '{16'd3, 16'd4, 16'd5, 16'd3, 16'd4};
        do_start(16'd5, 16'd3, 16'd5, 1'b1, 8'd2);
        for (int p = 0; p < 5; p++) begin
            n_cmp++;
            if (app_early_v_o !== 1'b1 || app_pkt_len_o !== exp_len[p]) begin
                n_err++; $display("FAIL inc_req%0d: early=%b plen=%0d expected 1/%0d",
                                  p, app_early_v_o, app_pkt_len_o, exp_len[p]);
            end
            @(negedge clk);
            repeat (int'(exp_len[p]) / 2) @(negedge clk);
            n_cmp++;
            if (app_last_o !== 1'b1 || app_len_o !== 2'(exp_len[p] % 2)) begin
                n_err++; $display("FAIL inc_last%0d: last=%b len=%0d", p, app_last_o, app_len_o);
            end
            @(negedge clk);
            if (p < 4) begin
                for (int g = 0; g < 2; g++) begin
                    n_cmp++;
                    if (app_early_v_o !== 1'b0 || app_pkt_len_o !== 16'd0 || busy_o !== 1'b1) begin
                        n_err++; $display("FAIL inc_gap%0d_%0d: early=%b plen=%0d busy=%b expected 0/0/1",
                                          p, g, app_early_v_o, app_pkt_len_o, busy_o);
                    end
                    @(negedge clk);
                end
            end else begin
                n_cmp++;
                if (done_o !== 1'b1 || pkt_sent_o !== 16'd5) begin
                    n_err++; $display("FAIL inc_done: done=%b sent=%0d expected 1/5", done_o, pkt_sent_o);
                end
            end
        end
    endtask

    task automatic test_ready_stall;
        app_ready_v_i = 1'b0;
        do_start(16'd1, 16'd4, 16'd4, 1'b0, 8'd0);
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if (app_early_v_o !== 1'b1 || app_pkt_len_o !== 16'd4 || app_len_o !== 2'd0) begin
                n_err++; $display("FAIL stall%0d: early=%b plen=%0d len=%0d expected 1/4/0",
                                  c, app_early_v_o, app_pkt_len_o, app_len_o);
            end
            @(negedge clk);
        end
        app_ready_v_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (app_early_v_o !== 1'b0 || app_len_o !== 2'd2 || app_data_o !== 16'hFFFE) begin
            n_err++; $display("FAIL stall_beat0: early=%b len=%0d data=%h expected 0/2/fffe",
                              app_early_v_o, app_len_o, app_data_o);
        end
        wait_idle("stall");
    endtask

    task automatic test_abort_data;
        do_start(16'd2, 16'd20, 16'd20, 1'b0, 8'd3);
        repeat (4) @(negedge clk);
        abort_i = 1'b1;
        #1;
        n_cmp++;
        if (app_cancel_o !== 1'b1 || app_last_o !== 1'b0 || app_early_v_o !== 1'b0) begin
            n_err++; $display("FAIL abort_cycle: cancel=%b last=%b early=%b expected 1/0/0",
                              app_cancel_o, app_last_o, app_early_v_o);
        end
        @(negedge clk);
        abort_i = 1'b0;
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (app_cancel_o !== 1'b0 || app_early_v_o !== 1'b0 || busy_o !== 1'b1 || pkt_sent_o !== 16'd0) begin
                n_err++; $display("FAIL abort_gap%0d: cancel=%b early=%b busy=%b sent=%0d expected 0/0/1/0",
                                  g, app_cancel_o, app_early_v_o, busy_o, pkt_sent_o);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (app_early_v_o !== 1'b1 || app_pkt_len_o !== 16'd20) begin
            n_err++; $display("FAIL abort_restart: early=%b plen=%0d expected 1/20", app_early_v_o, app_pkt_len_o);
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (pkt_sent_o !== 16'd1 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL abort_count: sent=%0d busy=%b expected 1/1", pkt_sent_o, busy_o);
        end
        wait_idle("abort_data");
        n_cmp++;
        if (pkt_sent_o !== 16'd2) begin
            n_err++; $display("FAIL abort_final: sent=%0d expected 2", pkt_sent_o);
        end
    endtask

    task automatic test_abort_last;
        do_start(16'd1, 16'd4, 16'd4, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        abort_i = 1'b1;
        #1;
        n_cmp++;
        if (app_last_o !== 1'b0 || app_cancel_o !== 1'b1) begin
            n_err++; $display("FAIL abort_last: last=%b cancel=%b expected 0/1", app_last_o, app_cancel_o);
        end
        @(negedge clk);
        abort_i = 1'b0;
        n_cmp++;
        if (pkt_sent_o !== 16'd0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL abort_last_cnt: sent=%0d done=%b busy=%b expected 0/0/1",
                              pkt_sent_o, done_o, busy_o);
        end
        @(negedge clk);
        n_cmp++;
        if (app_early_v_o !== 1'b1) begin
            n_err++; $display("FAIL abort_last_req: early=%b expected 1", app_early_v_o);
        end
        wait_idle("abort_last");
        n_cmp++;
        if (pkt_sent_o !== 16'd1) begin
            n_err++; $display("FAIL abort_last_final: sent=%0d expected 1", pkt_sent_o);
        end
    endtask

    task automatic test_reset_mid;
        do_start(16'd1, 16'd20, 16'd20, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
        nreset = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || app_data_o !== 16'h0 || app_len_o !== 2'd0 ||
            app_pkt_len_o !== 16'd0 || app_cancel_o !== 1'b0) begin
            n_err++; $display("FAIL rst_mid: busy=%b data=%h len=%0d plen=%0d cancel=%b expected all 0",
                              busy_o, app_data_o, app_len_o, app_pkt_len_o, app_cancel_o);
        end
        @(negedge clk);
        nreset = 1'b1;
        do_start(16'd1, 16'd20, 16'd20, 1'b0, 8'd0);
        @(negedge clk);
        n_cmp++;
        if (app_data_o !== 16'hFFFE) begin
            n_err++; $display("FAIL rst_restart: data=%h expected fffe", app_data_o);
        end
        wait_idle("rst_mid");
    endtask

    initial begin
        nreset = 1'b0; start_i = 1'b0; abort_i = 1'b0; len_inc_i = 1'b0;
        app_ready_v_i = 1'b1; pkt_cnt_i = '0; len_min_i = '0; len_max_i = '0; gap_i = '0;
        m_lfsr = 32'h1;
        #12;
        test_reset();
        test_fixed20();
        test_len5();
        test_inc();
        test_ready_stall();
        test_abort_data();
        test_abort_last();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
